// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, func codes,
// ALU operations, datapath mux selects and the controller state enum.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_SLT = 3'd4,
    ALU_NOP = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'd0,
    PC_SRC_ALUOUT = 2'd1,
    PC_SRC_JUMP   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } alusrc_b_e;

  typedef enum logic [3:0] {
    ST_RESET, ST_FETCH, ST_DECODE,
    ST_RTEXE, ST_RTWB, ST_ADDIEXE, ST_ADDIWB,
    ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR,
    ST_BRANCH, ST_BRANCH_NE, ST_JUMP
  } state_e;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type function decoder: maps the func field onto an ALU operation.
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_func,
  output alu_op_e    o_aluop
);

  always_comb begin
    case (i_func)
      FN_ADD:  o_aluop = ALU_ADD;
      FN_SUB:  o_aluop = ALU_SUB;
      FN_AND:  o_aluop = ALU_AND;
      FN_OR:   o_aluop = ALU_OR;
      FN_SLT:  o_aluop = ALU_SLT;
      default: o_aluop = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with bounded memory waits.
// Optional: define MC_CTRL_BNE_EN to decode bne (opcode 5) instead of trapping it.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W  = 4,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               regdst,
  output logic               mem2reg,
  output logic               regwrite,
  output logic               alusrc_a,
  output logic [1:0]         alusrc_b,
  output logic               extop,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op,
  output logic               mem_timeout
);

  state_e            r_state;
  state_e            w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  alu_op_e           w_rt_aluop;
  alu_op_e           w_aluop;
  logic              w_wait_state;
  logic              w_limit;

  mips_alu_dec u_alu_dec (
    .i_func  (func),
    .o_aluop (w_rt_aluop)
  );

  assign w_wait_state = (r_state == ST_FETCH) || (r_state == ST_MEMRD) ||
                        (r_state == ST_MEMWR);
  // A ready arriving on the limit cycle still wins, so the limit needs !mem_ready.
  assign w_limit      = (r_wait_cnt == WAIT_W'(WAIT_MAX)) && !mem_ready;
  assign aluop        = ALUOP_W'(w_aluop);

  // NOTE: state and counter use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RESET;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (mem_timeout || (w_next != r_state)) begin
        r_wait_cnt <= '0;
      end else if (w_wait_state && !mem_ready) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next      = r_state;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_ALU;
    ir_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    regdst      = 1'b0;
    mem2reg     = 1'b0;
    regwrite    = 1'b0;
    alusrc_a    = 1'b0;
    alusrc_b    = SRCB_RT;
    extop       = 1'b0;
    w_aluop     = ALU_NOP;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;

    case (r_state)
      ST_RESET: w_next = ST_FETCH;
      ST_FETCH: begin
        mem_read = 1'b1;
        alusrc_b = SRCB_FOUR;
        w_aluop  = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = ST_DECODE;
        end else if (w_limit) begin
          mem_timeout = 1'b1;
        end
      end
      ST_DECODE: begin
        alusrc_b = SRCB_IMM_SH2;
        extop    = 1'b1;
        w_aluop  = ALU_ADD;
        case (opcode)
          OP_RTYPE:     w_next = ST_RTEXE;
          OP_LW, OP_SW: w_next = ST_MEMADR;
          OP_BEQ:       w_next = ST_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       w_next = ST_BRANCH_NE;
`endif
          OP_ADDI:      w_next = ST_ADDIEXE;
          OP_J:         w_next = ST_JUMP;
          default: begin
            illegal_op = 1'b1;
            w_next     = ST_FETCH;
          end
        endcase
      end
      ST_RTEXE: begin
        alusrc_a = 1'b1;
        w_aluop  = w_rt_aluop;
        w_next   = ST_RTWB;
      end
      ST_RTWB: begin
        regdst   = 1'b1;
        mem2reg  = 1'b1;
        regwrite = 1'b1;
        w_aluop  = w_rt_aluop;
        w_next   = ST_FETCH;
      end
      ST_ADDIEXE, ST_MEMADR: begin
        alusrc_a = 1'b1;
        alusrc_b = SRCB_IMM;
        extop    = 1'b1;
        w_aluop  = ALU_ADD;
        if (r_state == ST_ADDIEXE) w_next = ST_ADDIWB;
        else w_next = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_ADDIWB: begin
        mem2reg  = 1'b1;
        regwrite = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          w_next = ST_MEMWB;
        end else if (w_limit) begin
          mem_timeout = 1'b1;
          w_next      = ST_FETCH;
        end
      end
      ST_MEMWB: begin
        regwrite = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          w_next = ST_FETCH;
        end else if (w_limit) begin
          mem_timeout = 1'b1;
          w_next      = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        alusrc_a = 1'b1;
        w_aluop  = ALU_SUB;
        pc_src   = PC_SRC_ALUOUT;
        pc_write = zero;
        w_next   = ST_FETCH;
      end
`ifdef MC_CTRL_BNE_EN
      ST_BRANCH_NE: begin
        alusrc_a = 1'b1;
        w_aluop  = ALU_SUB;
        pc_src   = PC_SRC_ALUOUT;
        pc_write = ~zero;
        w_next   = ST_FETCH;
      end
`endif
      ST_JUMP: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
        w_next   = ST_FETCH;
      end
      default: w_next = ST_RESET;
    endcase
  end

endmodule
